// File: rtl/det_engine_arbiter.sv
// det_engine_arbiter
//   Lets NREQ requesters share one determinant engine. The engine takes a
//   packed matrix and a level-held start, and returns done plus an 8-bit det.
//   A requester wins by round-robin. The arbiter captures the winner's matrix,
//   runs the engine start/done handshake and returns the result to the winner
//   as a one-cycle rsp_valid pulse. A watchdog aborts the transaction if the
//   engine never finishes. In that case rsp_err=1 and rsp_det=0.
// Ports
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   req         : per-requester request, held until its ack
//   req_matrix  : requester k matrix at [k*MAT_W +: MAT_W]
//   ack         : one-cycle pulse, request accepted and matrix captured
//   rsp_valid   : one-cycle pulse, result for the requester on rsp_det/rsp_err
//   rsp_det     : result byte; holds until the next response
//   rsp_err     : 1 when the engine timed out
//   busy        : high while a transaction is in flight
//   eng_matrix  : captured matrix driven to the engine
//   eng_start   : level start to the engine, dropped once done is seen
//   eng_done    : engine done, high while eng_start is high
//   eng_det     : engine result, valid while eng_done is high
module det_engine_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAT_W   = 200,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*MAT_W-1:0] req_matrix,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [7:0]            rsp_det,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [MAT_W-1:0]      eng_matrix,
  output logic                  eng_start,
  input  logic                  eng_done,
  input  logic [7:0]            eng_det
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [PW-1:0]       rr_ptr_r;
  logic [PW-1:0]       grant_r;
  logic [15:0]         wdog_r;
  logic [7:0]          det_q_r;
  logic                err_q_r;
  logic [NREQ-1:0]     ack_r;
  logic [NREQ-1:0]     rsp_valid_r;
  logic [7:0]          rsp_det_r;
  logic                rsp_err_r;
  logic                busy_r;
  logic [MAT_W-1:0]    eng_matrix_r;
  logic                eng_start_r;
  logic [PW:0]         pick_s;
  logic [PW-1:0]       win_s;
  logic                win_found_s;
  logic                timeout_s;

  // Round-robin pick: the MSB flags a winner, the low bits hold its index.
  // The scan starts at ptr and wraps modulo NREQ.
  function automatic logic [PW:0] pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] res;
    int          idx;
    res = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(p) + i) % NREQ;
      if (!res[PW] && r[idx]) begin
        res = {1'b1, PW'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
    if (g == PW'(NREQ - 1)) begin
      return '0;
    end else begin
      return g + PW'(1'b1);
    end
  endfunction

  // Winner selection and watchdog expiry.
  always_comb begin
    pick_s      = pick(req, rr_ptr_r);
    win_found_s = pick_s[PW];
    win_s       = pick_s[PW-1:0];
    timeout_s   = (wdog_r == 16'(TIMEOUT - 1));
  end

  // Next-state logic. In RUN, done is tested before the timeout, so done wins a tie.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (eng_done || timeout_s) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (!eng_done) begin
          state_s = RESP;
        end else begin
          state_s = DRAIN;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: grant capture, engine handshake, watchdog and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r     <= '0;
      grant_r      <= '0;
      wdog_r       <= 16'd0;
      det_q_r      <= 8'd0;
      err_q_r      <= 1'b0;
      ack_r        <= '0;
      rsp_valid_r  <= '0;
      rsp_det_r    <= 8'd0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
      eng_matrix_r <= '0;
      eng_start_r  <= 1'b0;
    end else begin
      ack_r       <= '0;
      rsp_valid_r <= '0;
      busy_r      <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (win_found_s) begin
            eng_matrix_r <= req_matrix[int'(win_s)*MAT_W +: MAT_W];
            ack_r        <= onehot(win_s);
            eng_start_r  <= 1'b1;
            grant_r      <= win_s;
            rr_ptr_r     <= next_ptr(win_s);
            wdog_r       <= 16'd0;
          end
        end
        RUN: begin
          if (eng_done) begin
            det_q_r     <= eng_det;
            err_q_r     <= 1'b0;
            eng_start_r <= 1'b0;
          end else if (timeout_s) begin
            det_q_r     <= 8'd0;
            err_q_r     <= 1'b1;
            eng_start_r <= 1'b0;
          end else begin
            wdog_r <= wdog_r + 16'd1;
          end
        end
        DRAIN: begin
          eng_start_r <= 1'b0;
        end
        RESP: begin
          rsp_valid_r <= onehot(grant_r);
          rsp_det_r   <= det_q_r;
          rsp_err_r   <= err_q_r;
        end
        default: begin
          eng_start_r <= 1'b0;
        end
      endcase
    end
  end

  assign ack        = ack_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_det    = rsp_det_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;
  assign eng_matrix = eng_matrix_r;
  assign eng_start  = eng_start_r;

endmodule

// File: tb/tb_det_engine_arbiter.sv
module tb_det_engine_arbiter;

  localparam int NREQ    = 4;
  localparam int MAT_W   = 200;
  localparam int TIMEOUT = 255;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*MAT_W-1:0] req_matrix;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       rsp_valid;
  logic [7:0]            rsp_det;
  logic                  rsp_err;
  logic                  busy;
  logic [MAT_W-1:0]      eng_matrix;
  logic                  eng_start;
  logic                  eng_done;
  logic [7:0]            eng_det;

  logic [MAT_W-1:0]      mat [NREQ];
  int                    errors = 0;
  int                    checks = 0;

  // engine stub settings
  int                    eng_lat  = 0;
  bit                    eng_hang = 1'b0;
  bit                    det_mode = 1'b0;
  logic [7:0]            det_val  = 8'd0;
  int                    eng_cnt  = 0;

  det_engine_arbiter #(.NREQ(NREQ), .MAT_W(MAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_matrix (req_matrix),
    .ack        (ack),
    .rsp_valid  (rsp_valid),
    .rsp_det    (rsp_det),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .eng_matrix (eng_matrix),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_det    (eng_det)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] fsum(input logic [MAT_W-1:0] m);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < MAT_W/8; i++) s = s + m[i*8 +: 8];
    return s;
  endfunction

  function automatic logic [MAT_W-1:0] rnd_mat();
    logic [223:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r = {r[191:0], 32'($urandom)};
    return r[MAT_W-1:0];
  endfunction

  // Engine stub: done comes eng_lat cycles after start rises and drops with start.
  always @(posedge clk) begin
    if (!eng_start) eng_cnt <= 0;
    else            eng_cnt <= eng_cnt + 1;
  end
  assign eng_done = eng_start && !eng_hang && (eng_cnt >= eng_lat);
  assign eng_det  = !eng_done ? 8'hA5 : (det_mode ? fsum(eng_matrix) : det_val);

  always_comb begin
    req_matrix = '0;
    for (int k = 0; k < NREQ; k++) req_matrix[k*MAT_W +: MAT_W] = mat[k];
  end

  task automatic chk(input string nm, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Bounded wait for a response; n = cycles waited, -1 if none arrived.
  task automatic wait_rsp(input int bound, output int n, output int starts);
    bit got;
    got    = 1'b0;
    n      = -1;
    starts = 0;
    for (int i = 1; i <= bound && !got; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        n   = i;
        got = 1'b1;
      end else begin
        starts += int'(eng_start);
      end
    end
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    int              lat;
    bit              hang;
    logic [7:0]      det_val;
    int              exp_g;
    int              exp_wait;
    logic [7:0]      exp_det;
    bit              exp_err;
    int              exp_start;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #900000;
    $display("FAIL global_timeout: run exceeded its time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int              n;
    int              starts;
    int              rcnt;
    bit              got;
    logic [NREQ-1:0] exp_a;
    logic [NREQ-1:0] exp_rv;
    logic [NREQ-1:0] prev_req;
    int              m_ptr;
    bit              m_out;
    bit              m_idle_prev;
    int              m_rsp_at;
    int              m_owner;
    logic [7:0]      m_det;
    bit              m_err;
    bit              found;
    int              w;
    int              k;
    int              lat;
    bit              hang;
    int              ngrants;

    // req, lat, hang, det_val, exp_g, exp_wait, exp_det, exp_err, exp_start
    tbl[0]  = '{4'b0100, 10,  1'b0, 8'd7,   2, 13,          8'd7,   1'b0, 11};
    tbl[1]  = '{4'b1111, 0,   1'b0, 8'h5A,  3, 3,           8'h5A,  1'b0, 1};
    tbl[2]  = '{4'b1111, 3,   1'b0, 8'hFF,  0, 6,           8'hFF,  1'b0, 4};
    tbl[3]  = '{4'b1111, 1,   1'b0, 8'h80,  1, 4,           8'h80,  1'b0, 2};
    tbl[4]  = '{4'b1111, 5,   1'b0, 8'h01,  2, 8,           8'h01,  1'b0, 6};
    tbl[5]  = '{4'b1111, 2,   1'b0, 8'h33,  3, 5,           8'h33,  1'b0, 3};
    tbl[6]  = '{4'b1111, 0,   1'b0, 8'h11,  0, 3,           8'h11,  1'b0, 1};
    tbl[7]  = '{4'b0001, 2,   1'b0, 8'h22,  0, 5,           8'h22,  1'b0, 3};
    tbl[8]  = '{4'b0010, 0,   1'b1, 8'h99,  1, TIMEOUT + 2, 8'h00,  1'b1, TIMEOUT};
    tbl[9]  = '{4'b0010, 4,   1'b0, 8'h44,  1, 7,           8'h44,  1'b0, 5};
    tbl[10] = '{4'b1000, 254, 1'b0, 8'hC3,  3, TIMEOUT + 2, 8'hC3,  1'b0, TIMEOUT};
    tbl[11] = '{4'b0110, 2,   1'b0, 8'h21,  1, 5,           8'h21,  1'b0, 3};

    for (int i = 0; i < NREQ; i++) mat[i] = rnd_mat();

    // Reset with all requests raised: outputs quiet, then requester 0 wins first.
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_ack", MAT_W'(ack), '0);
    chk("rst_rsp_valid", MAT_W'(rsp_valid), '0);
    chk("rst_rsp_det", MAT_W'(rsp_det), '0);
    chk("rst_rsp_err", MAT_W'(rsp_err), '0);
    chk("rst_busy", MAT_W'(busy), '0);
    chk("rst_eng_start", MAT_W'(eng_start), '0);
    chk("rst_eng_matrix", eng_matrix, '0);
    rst_n   = 1'b1;
    eng_lat = 2;
    det_val = 8'h3C;
    @(negedge clk);
    chk("rel_ack", MAT_W'(ack), MAT_W'(4'b0001));
    chk("rel_eng_matrix", eng_matrix, mat[0]);
    req = '0;
    wait_rsp(40, n, starts);
    chki("rel_rsp_wait", n, 5);

    // Table of single transactions, starting from a fresh rr pointer.
    do_reset();
    for (int r = 0; r < 12; r++) begin
      eng_lat  = tbl[r].lat;
      eng_hang = tbl[r].hang;
      det_val  = tbl[r].det_val;
      det_mode = 1'b0;
      req      = tbl[r].req;
      exp_a    = '0;
      exp_a[tbl[r].exp_g] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
        @(negedge clk);
        if (ack != '0) got = 1'b1;
      end
      chk($sformatf("v%0d_ack", r), MAT_W'(ack), MAT_W'(exp_a));
      chk($sformatf("v%0d_eng_matrix", r), eng_matrix, mat[tbl[r].exp_g]);
      req = '0;
      wait_rsp(tbl[r].exp_wait + 20, n, starts);
      starts += 1;
      chki($sformatf("v%0d_rsp_wait", r), n, tbl[r].exp_wait);
      chk($sformatf("v%0d_rsp_valid", r), MAT_W'(rsp_valid), MAT_W'(exp_a));
      chk($sformatf("v%0d_rsp_det", r), MAT_W'(rsp_det), MAT_W'(tbl[r].exp_det));
      chk($sformatf("v%0d_rsp_err", r), MAT_W'(rsp_err), MAT_W'(tbl[r].exp_err));
      chki($sformatf("v%0d_start_cycles", r), starts, tbl[r].exp_start);
      @(negedge clk);
      chk($sformatf("v%0d_busy_after", r), MAT_W'(busy), '0);
      chk($sformatf("v%0d_rsp_pulse", r), MAT_W'(rsp_valid), '0);
      chk($sformatf("v%0d_det_hold", r), MAT_W'(rsp_det), MAT_W'(tbl[r].exp_det));
    end

    // Reset during RUN: silent abort, pointer restarts at 0.
    eng_lat  = 10;
    eng_hang = 1'b0;
    req      = 4'b0100;
    @(negedge clk);
    chk("mid_ack", MAT_W'(ack), MAT_W'(4'b0100));
    req = '0;
    repeat (3) @(negedge clk);
    chk("mid_start_before", MAT_W'(eng_start), MAT_W'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("mid_start_async", MAT_W'(eng_start), '0);
    chk("mid_busy_async", MAT_W'(busy), '0);
    @(negedge clk);
    rst_n = 1'b1;
    rcnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) rcnt++;
    end
    chki("mid_no_rsp", rcnt, 0);
    eng_lat = 1;
    req     = 4'b1111;
    @(negedge clk);
    chk("mid_next_ack", MAT_W'(ack), MAT_W'(4'b0001));
    req = '0;
    wait_rsp(40, n, starts);
    chki("mid_next_wait", n, 4);

    // Randomized traffic against a transaction-level model.
    do_reset();
    det_mode    = 1'b1;
    prev_req    = '0;
    m_ptr       = 0;
    m_out       = 1'b0;
    m_idle_prev = 1'b1;
    m_rsp_at    = 0;
    m_owner     = 0;
    m_det       = 8'd0;
    m_err       = 1'b0;
    ngrants     = 0;
    for (int t = 1; t <= 4000; t++) begin
      @(negedge clk);
      exp_a  = '0;
      exp_rv = '0;
      if (m_idle_prev && prev_req != '0) begin
        found = 1'b0;
        w     = 0;
        for (int i = 0; i < NREQ; i++) begin
          k = (m_ptr + i) % NREQ;
          if (!found && prev_req[k]) begin
            found = 1'b1;
            w     = k;
          end
        end
        exp_a[w] = 1'b1;
        m_ptr    = (w + 1) % NREQ;
        m_out    = 1'b1;
        m_owner  = w;
        hang     = ($urandom_range(0, 19) == 0);
        lat      = $urandom_range(0, 12);
        eng_hang = hang;
        eng_lat  = lat;
        m_rsp_at = t + (hang ? TIMEOUT + 2 : lat + 3);
        m_det    = hang ? 8'd0 : fsum(mat[w]);
        m_err    = hang;
        ngrants++;
        chk($sformatf("rnd_t%0d_eng_matrix", t), eng_matrix, mat[w]);
      end else if (m_out && t == m_rsp_at) begin
        exp_rv[m_owner] = 1'b1;
        m_out = 1'b0;
        chk($sformatf("rnd_t%0d_rsp_det", t), MAT_W'(rsp_det), MAT_W'(m_det));
        chk($sformatf("rnd_t%0d_rsp_err", t), MAT_W'(rsp_err), MAT_W'(m_err));
      end
      m_idle_prev = !m_out;
      chk($sformatf("rnd_t%0d_ack", t), MAT_W'(ack), MAT_W'(exp_a));
      chk($sformatf("rnd_t%0d_rsp_valid", t), MAT_W'(rsp_valid), MAT_W'(exp_rv));
      chk($sformatf("rnd_t%0d_busy", t), MAT_W'(busy), MAT_W'(m_out));
      for (int q = 0; q < NREQ; q++) begin
        if (ack[q]) begin
          req[q] = 1'b0;
        end else if (!req[q]) begin
          if ($urandom_range(0, 5) == 0) begin
            mat[q] = rnd_mat();
            req[q] = 1'b1;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req[q] = 1'b0;
        end
      end
      prev_req = req;
    end
    checks++;
    if (ngrants < 20) begin
      errors++;
      $display("FAIL rnd_grant_count: got %0d expected at least 20", ngrants);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
